if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory.
- Owns the PC register and drives the memory read address.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirects from the hazard unit and the ID/EX stages.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/if_stage_if_id_reg.sv | 57 +++++
 rtl/if_stage.sv | 119 +++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: datapath width,
// the NOP encoding, instruction field positions and the next-PC select codes.
package mips_pkg;

    localparam int XLEN = 32;

    // All-zero word decodes as sll $0,$0,0, which has no architectural effect
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int INDEX_MSB  = 25;
    localparam int INDEX_LSB  = 0;
    localparam int INDEX_W    = INDEX_MSB - INDEX_LSB + 1;

    // Source of the next PC value
    typedef enum logic [1:0] {
        PCSEL_SEQ  = 2'd0,
        PCSEL_BR   = 2'd1,
        PCSEL_J    = 2'd2,
        PCSEL_HOLD = 2'd3
    } pcsel_e;

    // J-type target: upper nibble of the delay-slot PC, 26-bit index, word aligned
    function automatic logic [XLEN-1:0] jump_target(
        input logic [XLEN-1:0]    pc_plus4,
        input logic [INDEX_W-1:0] index
    );
        return {pc_plus4[XLEN-1:XLEN-4], index, 2'b00};
    endfunction

    // Clears the byte offset so the PC can never become misaligned
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and its PC+4.
// Flush squashes the contents to a NOP bubble and takes priority over a
// held (write-disabled) register, so a redirect always clears the slot.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write_en_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q,    instr_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q,    valid_d;

    // Next contents: flush beats capture, capture beats hold
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (write_en_i) begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    // Register update with synchronous reset to an empty bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous-read
// instruction memory and loads the IF/ID register one cycle later.
// Redirects (branch, then jump) override a hazard stall on the PC.
// Optional macro FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               ifid_flush,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               jump,
    input  logic [INDEX_W-1:0] jump_index,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [XLEN-1:0]    imem_instr,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    if_id_pc_plus4,
    output logic [XLEN-1:0]    if_id_instr,
    output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        bubble_count
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    pcsel_e          pc_sel;

    // Sequential address wraps naturally at 2^32
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    // Next-PC source: the older branch beats the younger jump, and both beat a stall
    always_comb begin
        pc_sel = PCSEL_HOLD;
        if (branch_taken) begin
            pc_sel = PCSEL_BR;
        end else if (jump) begin
            pc_sel = PCSEL_J;
        end else if (pc_write) begin
            pc_sel = PCSEL_SEQ;
        end
    end

    // Next-PC mux; redirect targets are word aligned so the low bits stay 0
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PCSEL_SEQ:  pc_d = pc_plus4;
            PCSEL_BR:   pc_d = word_align(branch_target);
            PCSEL_J:    pc_d = jump_target(if_id_pc_plus4, jump_index);
            PCSEL_HOLD: pc_d = pc_q;
            default:    pc_d = pc_q;
        endcase
    end

    // PC register with synchronous reset to the boot address
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .write_en_i (ifid_write),
        .flush_i    (ifid_flush),
        .instr_i    (imem_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (if_id_instr),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    // A real load counts as a fetch; a squash or a held slot counts as a bubble
    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (ifid_flush || !ifid_write) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset and wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage. Two instances share stimulus: one boots at
// 0x0, the other at 0xFFFF_FFFC to exercise PC wrap. Expected state per edge
// comes from a small behavioural model and is queued; a monitor compares.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcWrite, ifidWrite, ifidFlush, branchTaken, jump;
    logic [31:0] branchTarget;
    logic [25:0] jumpIndex;

    logic [31:0] imemAddr0, imemInstr0, pc0, ifidPc4_0, ifidInstr0;
    logic [31:0] imemAddr1, imemInstr1, pc1, ifidPc4_1, ifidInstr1;
    logic        ifidValid0, ifidValid1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount0, bubbleCount0, fetchCount1, bubbleCount1;
`endif

    localparam logic [31:0] RESET0 = 32'h0000_0000;
    localparam logic [31:0] RESET1 = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] fetch;
        logic [31:0] bubble;
        string       tag;
    } model_t;

    model_t q0[$];
    model_t q1[$];
    model_t m0, m1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory content is a fixed, nonzero function of the address
    function automatic logic [31:0] imemModel(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3C3, a[15:0]};
    endfunction

    assign imemInstr0 = imemModel(imemAddr0);
    assign imemInstr1 = imemModel(imemAddr1);

    if_stage #(.RESET_PC(RESET0), .NOP_INSTR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .pc_write(pcWrite), .ifid_write(ifidWrite),
        .ifid_flush(ifidFlush), .branch_taken(branchTaken), .branch_target(branchTarget),
        .jump(jump), .jump_index(jumpIndex), .imem_addr(imemAddr0), .imem_instr(imemInstr0),
        .pc(pc0), .if_id_pc_plus4(ifidPc4_0), .if_id_instr(ifidInstr0), .if_id_valid(ifidValid0)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetchCount0), .bubble_count(bubbleCount0)
`endif
    );

    if_stage #(.RESET_PC(RESET1), .NOP_INSTR(32'h0)) dut1 (
        .clk(clk), .reset(reset), .pc_write(pcWrite), .ifid_write(ifidWrite),
        .ifid_flush(ifidFlush), .branch_taken(branchTaken), .branch_target(branchTarget),
        .jump(jump), .jump_index(jumpIndex), .imem_addr(imemAddr1), .imem_instr(imemInstr1),
        .pc(pc1), .if_id_pc_plus4(ifidPc4_1), .if_id_instr(ifidInstr1), .if_id_valid(ifidValid1)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetchCount1), .bubble_count(bubbleCount1)
`endif
    );

    // Behavioural next-state model of one fetch stage for one clock edge
    function automatic model_t nextModel(
        input model_t      m,
        input logic [31:0] resetPc,
        input logic        rst, pcw, ifw, fl, br,
        input logic [31:0] bt,
        input logic        j,
        input logic [25:0] ji
    );
        model_t      n;
        logic [31:0] seq;
        n   = m;
        seq = m.pc + 32'd4;
        if (rst) begin
            n.pc = resetPc; n.pc4 = 32'h0; n.instr = 32'h0; n.valid = 1'b0;
            n.fetch = 32'h0; n.bubble = 32'h0;
        end else begin
            if (br)       n.pc = {bt[31:2], 2'b00};
            else if (j)   n.pc = {m.pc4[31:28], ji, 2'b00};
            else if (pcw) n.pc = seq;
            if (fl) begin
                n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0;
            end else if (ifw) begin
                n.instr = imemModel(m.pc); n.pc4 = seq; n.valid = 1'b1;
            end
            if (fl || !ifw) n.bubble = m.bubble + 32'd1;
            else            n.fetch  = m.fetch + 32'd1;
        end
        return n;
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the expected state
    task automatic applyStimulus(
        input logic rst, pcw, ifw, fl, br,
        input logic [31:0] bt,
        input logic j,
        input logic [25:0] ji,
        input string tag
    );
        @(negedge clk);
        reset = rst; pcWrite = pcw; ifidWrite = ifw; ifidFlush = fl;
        branchTaken = br; branchTarget = bt; jump = j; jumpIndex = ji;
        m0 = nextModel(m0, RESET0, rst, pcw, ifw, fl, br, bt, j, ji);
        m1 = nextModel(m1, RESET1, rst, pcw, ifw, fl, br, bt, j, ji);
        m0.tag = {tag, "/dut0"};
        m1.tag = {tag, "/dut1"};
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int which, input model_t e);
        if (which == 0) begin
            checkField({e.tag, " pc"},        pc0,        e.pc);
            checkField({e.tag, " imem_addr"}, imemAddr0,  e.pc);
            checkField({e.tag, " pc_plus4"},  ifidPc4_0,  e.pc4);
            checkField({e.tag, " instr"},     ifidInstr0, e.instr);
            checkField({e.tag, " valid"},     {31'h0, ifidValid0}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
            checkField({e.tag, " fetch_count"},  fetchCount0,  e.fetch);
            checkField({e.tag, " bubble_count"}, bubbleCount0, e.bubble);
`endif
        end else begin
            checkField({e.tag, " pc"},        pc1,        e.pc);
            checkField({e.tag, " imem_addr"}, imemAddr1,  e.pc);
            checkField({e.tag, " pc_plus4"},  ifidPc4_1,  e.pc4);
            checkField({e.tag, " instr"},     ifidInstr1, e.instr);
            checkField({e.tag, " valid"},     {31'h0, ifidValid1}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
            checkField({e.tag, " fetch_count"},  fetchCount1,  e.fetch);
            checkField({e.tag, " bubble_count"}, bubbleCount1, e.bubble);
`endif
        end
    endtask

    // Monitor: after every rising edge, retire one queued expectation per DUT
    always @(posedge clk) begin
        model_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput(0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput(1, e);
        end
    end

    initial begin
        m0 = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ""};
        m1 = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ""};
        reset = 1'b1; pcWrite = 1'b0; ifidWrite = 1'b0; ifidFlush = 1'b0;
        branchTaken = 1'b0; branchTarget = 32'h0; jump = 1'b0; jumpIndex = 26'h0;

        //                rst  pcw  ifw  fl   br   target        j    index
        applyStimulus(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0, "reset");
        applyStimulus(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0, "reset");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, "run");
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,    1'b0,26'h0, "stall");
        applyStimulus(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,26'h0, "resume");
        applyStimulus(1'b0,1'b0,1'b1,1'b1,1'b1,32'h0000_007C,1'b0,26'h0, "branch_flush");
        applyStimulus(1'b0,1'b1,1'b1,1'b0,1'b1,32'h0000_0077,1'b0,26'h0, "branch_mask");
        applyStimulus(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,26'h0, "run2");
        applyStimulus(1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,26'h17,"jump");
        applyStimulus(1'b0,1'b0,1'b1,1'b1,1'b1,32'h0000_0040,1'b1,26'h17,"br_over_j");
        applyStimulus(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,26'h0, "run3");
        applyStimulus(1'b0,1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0, "flush_over_hold");
        applyStimulus(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0, "stall2");
        applyStimulus(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0, "reset_stall");
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, "run4");

        // Let the monitor drain; leftover expectations mean missed comparisons
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
